// File: rtl/module_spi_slave_resp.sv
// SPI mode-0 responder: oversampled byte receiver that writes a data bank and
// returns bytes from a tx bank at the same address, with frame status.
module module_spi_slave_resp #(
    parameter int N = 32,
    localparam int AW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          sclk_i,
    input  logic          cs_n_i,
    input  logic          mosi_i,
    output logic          miso_o,
    output logic          miso_oe_o,
    input  logic [7:0]    data_tx_i,
    output logic [AW-1:0] addr_o,
    output logic          wr_data_o,
    output logic [31:0]   data_o,
    output logic [AW:0]   n_o,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic          err_o
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

    localparam logic [AW:0]   N_FULL   = (AW+1)'(N);
    localparam logic [AW-1:0] ADDR_MAX = AW'(N - 1);

    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) rst_sync <= '0;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // cs_n is synchronised with reset value 0 so a reset taken while the
    // master holds cs_n low never looks like a fresh cs_n fall.
    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every flop samples the pre-edge value of its neighbours.
            sclk_q <= {sclk_q[1:0], sclk_i};
            cs_q   <= {cs_q[1:0], cs_n_i};
            mosi_q <= {mosi_q[0], mosi_i};
        end
    end

    logic cs_n_s, mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall;
    assign cs_n_s    = cs_q[1];
    assign mosi_s    = mosi_q[1];
    assign sclk_rise =  sclk_q[1] & ~sclk_q[2] & ~cs_n_s;
    assign sclk_fall = ~sclk_q[1] &  sclk_q[2] & ~cs_n_s;
    assign cs_rise   =  cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] &  cs_q[2];

    state_t        state_q, state_d;
    logic [3:0]    bit_cnt;
    logic [7:0]    rx_sh, tx_sh;
    logic [AW-1:0] addr_q;
    logic [AW:0]   n_q;
    logic          busy_q, err_q, full;

    assign full = (n_q == N_FULL);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d      = state_q;
        wr_data_o    = 1'b0;
        frame_done_o = 1'b0;
        unique case (state_q)
            IDLE:  if (cs_fall) state_d = LOAD;
            LOAD:  state_d = cs_rise ? DONE : SHIFT;
            SHIFT: begin
                if (cs_rise)                          state_d = DONE;
                else if (sclk_rise && bit_cnt == 4'd7) state_d = STORE;
            end
            STORE: begin
                wr_data_o = ~full;
                state_d   = cs_rise ? DONE : LOAD;
            end
            DONE: begin
                frame_done_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            rx_sh   <= '0;
            tx_sh   <= '0;
            addr_q  <= '0;
            n_q     <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (cs_fall) begin
                    addr_q  <= '0;
                    n_q     <= '0;
                    err_q   <= 1'b0;
                    bit_cnt <= '0;
                    busy_q  <= 1'b1;
                end
                LOAD: tx_sh <= full ? 8'h00 : data_tx_i;
                SHIFT: begin
                    if (cs_rise) begin
                        if (bit_cnt != 4'd0) err_q <= 1'b1;
                    end else if (sclk_rise) begin
                        rx_sh   <= {rx_sh[6:0], mosi_s};
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (sclk_fall && bit_cnt != 4'd0 && bit_cnt < 4'd8) begin
                        tx_sh <= {tx_sh[6:0], 1'b0};
                    end
                end
                STORE: begin
                    bit_cnt <= '0;
                    if (!full) begin
                        n_q <= n_q + (AW+1)'(1);
                        if (addr_q < ADDR_MAX) addr_q <= addr_q + AW'(1);
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                DONE: busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign miso_o    = tx_sh[7];
    assign miso_oe_o = busy_q & ~cs_n_s;
    assign addr_o    = addr_q;
    assign n_o       = n_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;
    assign data_o    = {24'b0, rx_sh};

endmodule

// File: tb/tb_module_spi_slave_resp.sv
// Self-checking bench: a bit-banged SPI master drives a 32-deep and a 4-deep
// responder; results are compared with a per-frame behavioural model.
module tb_module_spi_slave_resp;

    localparam int HALF = 8;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic       reset_n_i, sclk_i, mosi_i;
    logic [1:0] cs_n;

    logic        miso_a, oe_a, wr_a, busy_a, done_a, err_a;
    logic [7:0]  dtx_a;
    logic [4:0]  addr_a;
    logic [31:0] data_a;
    logic [5:0]  n_a;

    logic        miso_b, oe_b, wr_b, busy_b, done_b, err_b;
    logic [7:0]  dtx_b;
    logic [1:0]  addr_b;
    logic [31:0] data_b;
    logic [2:0]  n_b;

    logic [7:0] tx_a [32];
    logic [7:0] tx_b [4];
    assign dtx_a = tx_a[addr_a];
    assign dtx_b = tx_b[addr_b];

    module_spi_slave_resp #(.N(32)) u_dut_a (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .sclk_i(sclk_i), .cs_n_i(cs_n[0]),
        .mosi_i(mosi_i), .miso_o(miso_a), .miso_oe_o(oe_a), .data_tx_i(dtx_a),
        .addr_o(addr_a), .wr_data_o(wr_a), .data_o(data_a), .n_o(n_a),
        .busy_o(busy_a), .frame_done_o(done_a), .err_o(err_a)
    );

    module_spi_slave_resp #(.N(4)) u_dut_b (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .sclk_i(sclk_i), .cs_n_i(cs_n[1]),
        .mosi_i(mosi_i), .miso_o(miso_b), .miso_oe_o(oe_b), .data_tx_i(dtx_b),
        .addr_o(addr_b), .wr_data_o(wr_b), .data_o(data_b), .n_o(n_b),
        .busy_o(busy_b), .frame_done_o(done_b), .err_o(err_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Write strobes and frame-done pulses are one clk wide; capture at negedge.
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          done_cnt = 0;

    always @(negedge clk_i) begin
        if (wr_a) begin wq_addr.push_back(32'(addr_a)); wq_data.push_back(data_a); end
        if (wr_b) begin wq_addr.push_back(32'(addr_b)); wq_data.push_back(data_b); end
        if (done_a | done_b) done_cnt++;
    end

    int         sel;
    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    function automatic logic cur_miso();   return sel ? miso_b : miso_a; endfunction
    function automatic logic cur_oe();     return sel ? oe_b : oe_a; endfunction
    function automatic logic cur_err();    return sel ? err_b : err_a; endfunction
    function automatic logic cur_busy();   return sel ? busy_b : busy_a; endfunction
    function automatic int   cur_n();      return sel ? int'(n_b) : int'(n_a); endfunction
    function automatic int   cur_depth();  return sel ? 4 : 32; endfunction
    function automatic logic [7:0] cur_tx(input int i);
        return sel ? tx_b[i] : tx_a[i];
    endfunction

    // Master: nbytes full bytes, then `partial` extra bits; reset pulsed at
    // bit rst_bit of the first byte when rst_bit >= 0.
    task automatic spi_frame(input int nbytes, input int partial, input int rst_bit);
        logic [7:0] tb, rx;
        int nb;
        m_rx.delete();
        wq_addr.delete();
        wq_data.delete();
        cs_n[sel] = 1'b0;
        wait_clk(10);
        for (int b = 0; b < nbytes + (partial > 0 ? 1 : 0); b++) begin
            nb = (b < nbytes) ? 8 : partial;
            tb = m_tx[b];
            rx = 8'h00;
            for (int i = 0; i < nb; i++) begin
                mosi_i = tb[7-i];
                wait_clk(HALF);
                if (b == 0 && i == 0 && rst_bit < 0) check("miso_oe_active", 32'(cur_oe()), 32'd1);
                rx = {rx[6:0], cur_miso()};
                sclk_i = 1'b1;
                if (b == 0 && i == rst_bit) begin
                    reset_n_i = 1'b0;
                    wait_clk(2);
                    reset_n_i = 1'b1;
                    wait_clk(HALF - 2);
                end else begin
                    wait_clk(HALF);
                end
                sclk_i = 1'b0;
            end
            if (nb == 8) m_rx.push_back(rx);
        end
        wait_clk(HALF);
        cs_n[sel] = 1'b1;
        mosi_i    = 1'b0;
        wait_clk(12);
    endtask

    // Model: the first min(k,N) bytes are written to addresses 0.., every full
    // byte returns tx[i] (or 0 past the bank), err flags overflow or leftovers.
    task automatic run_and_check(input string tag, input int nbytes, input int partial);
        int d0, depth, stored, lim;
        d0     = done_cnt;
        depth  = cur_depth();
        stored = (nbytes < depth) ? nbytes : depth;
        spi_frame(nbytes, partial, -1);
        check({tag, "_n"},    32'(cur_n()), 32'(stored));
        check({tag, "_err"},  32'(cur_err()), 32'((partial != 0) || (nbytes > depth)));
        check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_busy"}, 32'(cur_busy()), 32'd0);
        check({tag, "_oe"},   32'(cur_oe()), 32'd0);
        check({tag, "_nwr"},  32'(wq_addr.size()), 32'(stored));
        lim = (wq_addr.size() < stored) ? wq_addr.size() : stored;
        for (int i = 0; i < lim; i++) begin
            check($sformatf("%s_waddr%0d", tag, i), wq_addr[i], 32'(i));
            check($sformatf("%s_wdata%0d", tag, i), wq_data[i], {24'b0, m_tx[i]});
        end
        for (int i = 0; i < m_rx.size(); i++)
            check($sformatf("%s_rx%0d", tag, i), 32'(m_rx[i]),
                  32'((i < depth) ? cur_tx(i) : 8'h00));
    endtask

    initial begin
        int d0, nb, pb;
        reset_n_i = 1'b0;
        sclk_i    = 1'b0;
        mosi_i    = 1'b0;
        cs_n      = 2'b11;
        sel       = 0;
        for (int i = 0; i < 32; i++) tx_a[i] = 8'($urandom);
        for (int i = 0; i < 4; i++)  tx_b[i] = 8'($urandom);

        // Reset with sclk toggling and cs_n high.
        for (int i = 0; i < 12; i++) begin
            if (i == 4) reset_n_i = 1'b1;
            sclk_i = ~sclk_i;
            mosi_i = 1'($urandom);
            wait_clk(HALF);
        end
        sclk_i = 1'b0;
        wait_clk(4);
        check("rst_nwr",  32'(wq_addr.size()), 32'd0);
        check("rst_oe",   32'({oe_a, oe_b}), 32'd0);
        check("rst_miso", 32'({miso_a, miso_b}), 32'd0);
        check("rst_addr", 32'({addr_a, addr_b}), 32'd0);
        check("rst_n",    32'({n_a, n_b}), 32'd0);
        check("rst_flags", 32'({busy_a, busy_b, err_a, err_b}), 32'd0);
        check("rst_data", data_a | data_b, 32'd0);
        check("rst_done", 32'(done_cnt), 32'd0);

        // Single byte.
        tx_a[0] = 8'h3C;
        m_tx = '{8'hA5};
        run_and_check("one", 1, 0);

        // Three bytes.
        tx_a[0] = 8'h11; tx_a[1] = 8'h22; tx_a[2] = 8'h33;
        m_tx = '{8'hC1, 8'hC2, 8'hC3};
        run_and_check("three", 3, 0);

        // cs_n rises after 5 bits of byte 2.
        m_tx = '{8'($urandom), 8'($urandom)};
        run_and_check("partial", 1, 5);

        // Overflow on the 4-deep bank.
        sel = 1;
        m_tx.delete();
        for (int i = 0; i < 6; i++) m_tx.push_back(8'($urandom));
        run_and_check("ovf", 6, 0);

        // Reset during bit 4 of byte 1, cs_n still low afterwards.
        sel = 0;
        d0  = done_cnt;
        m_tx = '{8'($urandom)};
        spi_frame(1, 0, 4);
        check("midrst_nwr",  32'(wq_addr.size()), 32'd0);
        check("midrst_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_n",    32'(n_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        tx_a[0] = 8'h3C;
        m_tx = '{8'hA5};
        run_and_check("after_rst", 1, 0);

        // Randomised frames on both banks.
        for (int r = 0; r < 6; r++) begin
            sel = int'($urandom_range(0, 1));
            nb  = int'($urandom_range(1, sel ? 6 : 4));
            pb  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
            m_tx.delete();
            for (int i = 0; i <= nb; i++) m_tx.push_back(8'($urandom));
            for (int i = 0; i < 4; i++) begin
                tx_a[i] = 8'($urandom);
                tx_b[i] = 8'($urandom);
            end
            run_and_check($sformatf("rnd%0d", r), nb, pb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
